// File: rtl/proc_instr_sequencer.sv
// Program sequencer: stores a short program, issues one instruction at a
// time to the processor and queues each {zero_flag, result} in a FIFO.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   prog_we/addr/wdata  program memory write (accepted only when idle)
//   prog_len, start     run length and run request pulse
//   instruction,
//   instr_valid         issue interface to the processor
//   result, zero_flag,
//   proc_ready          processor completion interface
//   busy, done,
//   timeout_err         run status
//   res_rd_en, res_rd_data, res_rd_zero,
//   res_empty, res_count  show-ahead result FIFO read side
//
// Optional: define SEQ_TIMEOUT_EN to add a WAIT watchdog that records
// 32'hDEAD_DEAD for an instruction whose completion never arrives.

module proc_instr_sequencer #(
    parameter int PROG_DEPTH     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_wdata,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          start,
    output logic [31:0]                   instruction,
    output logic                          instr_valid,
    input  logic [31:0]                   result,
    input  logic                          zero_flag,
    input  logic                          proc_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    input  logic                          res_rd_en,
    output logic [31:0]                   res_rd_data,
    output logic                          res_rd_zero,
    output logic                          res_empty,
    output logic [$clog2(FIFO_DEPTH):0]   res_count
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] C_FULL = (FW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0] r_prog [PROG_DEPTH];
    logic [AW:0] r_pc;
    logic [AW:0] r_len;
    logic [AW:0] w_pc_inc;
    logic [31:0] r_instr;
    logic        r_seen_low;
    logic        r_done;

    logic [31:0] r_fifo_data [FIFO_DEPTH];
    logic        r_fifo_zero [FIFO_DEPTH];
    logic [FW-1:0] r_wptr;
    logic [FW-1:0] r_rptr;
    logic [FW:0]   r_count;

    logic        w_full;
    logic        w_complete;
    logic        w_to_hit;
    logic        w_to_push;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_push_data;
    logic        w_push_zero;
    logic [31:0] w_cur_instr;

    assign w_full      = (r_count == C_FULL);
    assign w_pc_inc    = r_pc + 1'b1;
    assign w_cur_instr = r_prog[r_pc[AW-1:0]];
    // Completion needs a low sample after the issue, so a ready level
    // left high from the previous instruction is not mistaken for it.
    assign w_complete  = r_seen_low & proc_ready;
    assign w_push      = (r_state == S_CAPTURE);
    assign w_pop       = res_rd_en & (r_count != '0);
    assign w_push_data = w_to_push ? 32'hDEAD_DEAD : result;
    assign w_push_zero = w_to_push ? 1'b0 : zero_flag;

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign instruction = (r_state == S_ISSUE) ? w_cur_instr : r_instr;
    assign res_empty   = (r_count == '0);
    assign res_count   = r_count;
    assign res_rd_data = res_empty ? 32'h0 : r_fifo_data[r_rptr];
    assign res_rd_zero = res_empty ? 1'b0 : r_fifo_zero[r_rptr];

    always_comb begin
        w_next      = r_state;
        instr_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (prog_len == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!w_full) begin
                    instr_valid = 1'b1;
                    w_next      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_complete || w_to_hit) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next = (w_pc_inc == r_len) ? S_FINISH : S_ISSUE;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_len      <= '0;
            r_instr    <= '0;
            r_seen_low <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len <= prog_len;
                        r_pc  <= '0;
                    end
                end
                S_ISSUE: begin
                    r_instr    <= w_cur_instr;
                    r_seen_low <= 1'b0;
                end
                S_WAIT: begin
                    if (!proc_ready) begin
                        r_seen_low <= 1'b1;
                    end
                end
                S_CAPTURE: r_pc <= w_pc_inc;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && r_state == S_IDLE) begin
            r_prog[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= w_push_data;
            r_fifo_zero[r_wptr] <= w_push_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] C_TLIM = (TW)'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_wcnt;
    logic          r_to;
    logic          r_terr;

    assign w_to_hit    = (r_state == S_WAIT) && !w_complete
                         && (r_wcnt == C_TLIM);
    assign w_to_push   = r_to;
    assign timeout_err = r_terr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
            r_to   <= 1'b0;
            r_terr <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_terr <= 1'b0;
            end
            if (r_state == S_ISSUE) begin
                r_wcnt <= '0;
                r_to   <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            // The flag carries into CAPTURE so the marker word is pushed.
            if (w_to_hit) begin
                r_to   <= 1'b1;
                r_terr <= 1'b1;
            end
        end
    end
`else
    logic w_unused_to;

    assign w_to_hit    = 1'b0;
    assign w_to_push   = 1'b0;
    assign timeout_err = 1'b0;
    assign w_unused_to = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_proc_instr_sequencer.sv
// Randomized bench for proc_instr_sequencer with a processor model,
// an expected-result queue and an issue log compared against the program.

module tb_proc_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [31:0] prog_wdata = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] result = '0;
    logic        zero_flag = 1'b0;
    logic        proc_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        res_rd_en = 1'b0;
    logic [31:0] res_rd_data;
    logic        res_rd_zero;
    logic        res_empty;
    logic [3:0]  res_count;

    proc_instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .prog_len    (prog_len),
        .start       (start),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .result      (result),
        .zero_flag   (zero_flag),
        .proc_ready  (proc_ready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .res_rd_en   (res_rd_en),
        .res_rd_data (res_rd_data),
        .res_rd_zero (res_rd_zero),
        .res_empty   (res_empty),
        .res_count   (res_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_done = 0;

    logic [31:0] pmem [16];
    logic [31:0] resp_q [$];
    logic [63:0] exp_q [$];
    logic [31:0] issue_log [$];
    int          issue_t [$];
    bit          hang = 1'b0;
    bit          pend = 1'b0;
    int          lat = 0;
    logic [31:0] held;
    logic [31:0] rv;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst && done) n_done <= n_done + 1;
    end

    // Processor: ready drops after an issue and rises 4 cycles after it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            proc_ready <= 1'b1;
            pend = 1'b0;
            lat  = 0;
        end else if (instr_valid) begin
            pend = 1'b1;
            lat  = 1;
            held = instruction;
            proc_ready <= 1'b0;
            issue_log.push_back(instruction);
            issue_t.push_back(cyc);
        end else if (pend) begin
            lat++;
            if (lat == 4 && !hang) begin
                check("instr_stable", instruction, held);
                if (resp_q.size() != 0) rv = resp_q.pop_front();
                else if ($urandom_range(0, 3) == 0) rv = 32'h0;
                else rv = $urandom;
                result     <= rv;
                zero_flag  <= (rv == 32'h0);
                proc_ready <= 1'b1;
                pend = 1'b0;
                exp_q.push_back({31'b0, rv == 32'h0, rv});
            end
        end
    end

    task automatic prog_write(input int a, input logic [31:0] d);
        prog_we    = 1'b1;
        prog_addr  = a[3:0];
        prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
        pmem[a] = d;
    endtask

    task automatic start_run(input int len);
        prog_len = len[4:0];
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_logs();
        issue_log.delete();
        issue_t.delete();
    endtask

    task automatic wait_done(input string tag, input int d0,
                             input int budget);
        int k = 0;
        while (n_done == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, n_done != d0, 1);
    endtask

    task automatic wait_issues(input string tag, input int n,
                               input int budget);
        int k = 0;
        while (issue_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_issue_wait"}, issue_log.size() >= n, 1);
    endtask

    task automatic pop_one(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {31'b0, res_rd_zero, res_rd_data}, e);
        end
        res_rd_en = 1'b1;
        @(negedge clk);
        res_rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 64 && !res_empty; i++) pop_one(tag);
        check({tag, "_empty"}, res_empty, 1);
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    task automatic check_prog(input string tag, input int len);
        check({tag, "_n_issue"}, issue_log.size(), len);
        for (int i = 0; i < len && i < issue_log.size(); i++)
            check({tag, "_instr"}, issue_log[i], pmem[i]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_instr"}, instruction, 0);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_terr"}, timeout_err, 0);
        check({tag, "_empty"}, res_empty, 1);
        check({tag, "_count"}, res_count, 0);
        check({tag, "_rdata"}, res_rd_data, 0);
        check({tag, "_rzero"}, res_rd_zero, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int len;
        bit fin;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_rel");

        // Directed three-instruction program
        prog_write(0, 32'h0400_0000);
        prog_write(1, 32'h1400_0000);
        prog_write(2, 32'h0000_0000);
        resp_q = '{32'h11, 32'h22, 32'h0};
        clear_logs();
        d0 = n_done;
        start_run(3);
        wait_done("t1", d0, 100);
        repeat (3) @(negedge clk);
        check("t1_done_once", n_done - d0, 1);
        check("t1_busy", busy, 0);
        check_prog("t1", 3);
        for (int i = 1; i < issue_t.size(); i++)
            check("t1_space", issue_t[i] - issue_t[i-1], 6);
        check("t1_count", res_count, 3);
        check("t1_head", res_rd_data, 32'h11);
        drain("t1_pop");

        // Full FIFO stalls ISSUE; pops release it
        for (int i = 0; i < 16; i++) prog_write(i, $urandom);
        clear_logs();
        d0 = n_done;
        start_run(10);
        repeat (100) @(negedge clk);
        check("t2_count_full", res_count, 8);
        check("t2_issues8", issue_log.size(), 8);
        check("t2_stall_valid", instr_valid, 0);
        check("t2_busy", busy, 1);
        pop_one("t2_pop1");
        repeat (20) @(negedge clk);
        check("t2_issues9", issue_log.size(), 9);
        check("t2_count_refill", res_count, 8);
        for (int k = 0; k < 400; k++) begin
            if (n_done != d0 && res_empty) break;
            if (!res_empty) pop_one("t2_pop");
            else @(negedge clk);
        end
        check("t2_done_once", n_done - d0, 1);
        check_prog("t2", 10);
        check("t2_exp_left", exp_q.size(), 0);

        // Zero-length run
        clear_logs();
        d0 = n_done;
        prog_len = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_busy", busy, 1);
        check("t3_done_early", done, 0);
        @(negedge clk);
        check("t3_done", done, 1);
        @(negedge clk);
        check("t3_done_off", done, 0);
        check("t3_done_once", n_done - d0, 1);
        check("t3_no_issue", issue_log.size(), 0);
        check("t3_empty", res_empty, 1);

        // Program write and start while busy are ignored
        clear_logs();
        d0 = n_done;
        start_run(4);
        wait_issues("t4", 1, 50);
        prog_we    = 1'b1;
        prog_addr  = 4'd0;
        prog_wdata = ~pmem[0];
        prog_len   = 5'd1;
        start      = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
        start   = 1'b0;
        wait_done("t4", d0, 200);
        check_prog("t4", 4);
        drain("t4_pop");
        clear_logs();
        d0 = n_done;
        start_run(1);
        wait_done("t4r", d0, 50);
        check_prog("t4r", 1);
        drain("t4r_pop");

        // Reset in WAIT of the second instruction
        clear_logs();
        start_run(4);
        wait_issues("t5", 2, 50);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("t5_rst");
        exp_q.delete();
        resp_q.delete();
        clear_logs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d0 = n_done;
        start_run(2);
        wait_done("t5r", d0, 100);
        check_prog("t5r", 2);
        drain("t5r_pop");

        // Random programs, lengths and pops
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) prog_write(i, $urandom);
            clear_logs();
            d0 = n_done;
            start_run(len);
            fin = 1'b0;
            for (int k = 0; k < 800 && !fin; k++) begin
                if (n_done != d0 && res_empty) fin = 1'b1;
                else if (!res_empty && $urandom_range(0, 1) == 1)
                    pop_one("rnd_pop");
                else @(negedge clk);
            end
            check("rnd_done_once", n_done - d0, 1);
            check_prog("rnd", len);
            check("rnd_exp_left", exp_q.size(), 0);
        end

`ifdef SEQ_TIMEOUT_EN
        // Processor never completes: watchdog records marker words
        hang = 1'b1;
        clear_logs();
        d0 = n_done;
        start_run(2);
        wait_done("t6", d0, 400);
        check("t6_terr", timeout_err, 1);
        check("t6_issues", issue_log.size(), 2);
        check("t6_count", res_count, 2);
        check("t6_head", {res_rd_zero, res_rd_data}, {1'b0, 32'hDEAD_DEAD});
        res_rd_en = 1'b1;
        @(negedge clk);
        res_rd_en = 1'b0;
        check("t6_head2", {res_rd_zero, res_rd_data},
              {1'b0, 32'hDEAD_DEAD});
        res_rd_en = 1'b1;
        @(negedge clk);
        res_rd_en = 1'b0;
        hang = 1'b0;
        check("t6_empty", res_empty, 1);
        d0 = n_done;
        start_run(1);
        check("t6_terr_clr", timeout_err, 0);
        wait_done("t6r", d0, 100);
        drain("t6r_pop");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/proc_instr_sequencer.md
Name: proc_instr_sequencer

Overview:
- Initiator-side companion to the processor host: stores a short program, issues instructions one at a time over the instr_valid/proc_ready interface, and collects each result and zero flag into a result FIFO.
- Sits between a configuration/test master and the processor host.
- Drives the instruction, instr_valid pair and consumes result, zero_flag, proc_ready.

Parameters:
- PROG_DEPTH, 16, program memory entries. Power of two, at least 2.
- FIFO_DEPTH, 8, result FIFO entries. Power of two, at least 2.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- prog_we  in  1  program memory write strobe
- prog_addr  in  log2(PROG_DEPTH)  program write address
- prog_wdata  in  32  program write data
- prog_len  in  log2(PROG_DEPTH)+1  number of instructions to run; sampled on start
- start  in  1  run request; single-cycle pulse
- instruction  out  32  instruction to processor
- instr_valid  out  1  issue strobe to processor
- result  in  32  processor result
- zero_flag  in  1  processor zero flag
- proc_ready  in  1  processor completion level
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at end of run
- timeout_err  out  1  sticky watchdog error; cleared on start
- res_rd_en  in  1  FIFO pop
- res_rd_data  out  32  FIFO head result (show-ahead)
- res_rd_zero  out  1  FIFO head zero flag
- res_empty  out  1  FIFO empty
- res_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: instruction=0, instr_valid=0, busy=0, done=0, timeout_err=0, res_empty=1, res_count=0, res_rd_data=0, res_rd_zero=0. Internal PC=0, state=IDLE.
- Program memory contents are not reset.
- prog_we writes take effect only in IDLE; while busy they are ignored.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, FINISH.
- IDLE, on start:
  - Latch prog_len, clear PC, clear timeout_err.
  - prog_len==0: go to FINISH.
  - Otherwise: go to ISSUE.
  - start is ignored when not in IDLE.
- ISSUE:
  - When res_count < FIFO_DEPTH, drive instruction=mem[PC] and assert instr_valid for exactly one cycle, then go to WAIT.
  - When the FIFO is full, stall with instr_valid=0.
- WAIT:
  - instruction is held stable, because the processor reads operand fields through its ALU cycle.
  - Track proc_ready: a 0 sample followed by a 1 sample (rising edge after the issue) marks completion; then go to CAPTURE.
  - A proc_ready level that was already high before the issue does not count as completion.
  - Nominal processor latency: proc_ready rises 4 cycles after the instr_valid cycle.
- CAPTURE:
  - Push {zero_flag, result} into the FIFO and increment PC.
  - PC==latched length: go to FINISH. Otherwise go to ISSUE.
  - Issue-to-issue spacing is 6 cycles minimum.
- FINISH: pulse done for 1 cycle, then go to IDLE.
- FIFO:
  - Circular buffer with pointers that wrap modulo FIFO_DEPTH.
  - Pop when res_rd_en and not empty; pop while empty is ignored.
  - A simultaneous push and pop leaves the count unchanged.
  - Overflow cannot occur: ISSUE is gated on space and only one instruction is outstanding.
  - res_rd_data and res_rd_zero show the head entry and are 0 when empty.
- PC width is log2(PROG_DEPTH)+1. Run length up to PROG_DEPTH. Address uses the low bits.
- rst mid-run aborts immediately:
  - FSM returns to IDLE and the FIFO is emptied.
  - The processor is expected to be reset by the same rst.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - Reaching TIMEOUT_CYCLES without completion sets timeout_err, pushes result=32'hDEAD_DEAD with zero flag 0, advances PC, and continues as in CAPTURE.
- Undefined:
  - WAIT has no limit.
  - timeout_err is tied to 0 and no counter logic exists.

Test Plan:
- Load 3 instructions (opcodes ADD, XOR, NOP = 32'h0400_0000, 32'h1400_0000, 32'h0000_0000), prog_len=3, start, with a processor model of 4-cycle latency returning 32'h11, 32'h22, 32'h0 -> three single-cycle instr_valid pulses spaced 6 cycles apart, instruction stable until proc_ready rises, FIFO holds 11/22/0 in order, res_count=3, done pulses once.
- FIFO_DEPTH=8, prog_len=10, no pops -> 8 results captured, sequencer stalls in ISSUE with instr_valid=0. Popping 1 entry -> 9th issue occurs. Popping all -> run completes and done pulses.
- prog_len=0, start -> done pulses 2 cycles after start, no instr_valid, FIFO remains empty.
- prog_we and start pulsed while busy -> memory unchanged (readback by rerun), run unaffected.
- rst asserted in WAIT of 2nd instruction -> all outputs at reset values immediately, res_empty=1. New start after release runs from PC 0.
- With SEQ_TIMEOUT_EN, model never raises proc_ready -> after 64 cycles timeout_err=1, FIFO entry 32'hDEAD_DEAD, sequencer proceeds to next instruction.
